// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle MIPS control sequencer; perf counters built only with MC_PERF_CNT_EN
module multicycle_controller #(
    parameter logic RESET_PC_WRITE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemToReg,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic        Jal,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [2:0]  ALUop,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPE_EX = 4'd6,
        RTYPE_WB = 4'd7,
        BRANCH   = 4'd8,
        ADDI_EX  = 4'd9,
        ADDI_WB  = 4'd10,
        JUMP     = 4'd11,
        JAL      = 4'd12,
        JR       = 4'd13
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    state_t      state_q;
    state_t      nxt;
    logic        run_q;
    logic        op_ok;
    logic        alu_funct_ok;
    logic [2:0]  funct_aluop;
    logic        in_fetch;

    logic        pcwrite_q, pcwritecond_q, iord_q, memread_q, memwrite_q;
    logic        memtoreg_q, regdst_q, regwrite_q, alusrca_q, jal_q;
    logic [1:0]  alusrcb_q, pcsource_q;
    logic [2:0]  aluop_q;

    logic        d_pcwrite, d_pcwritecond, d_iord, d_memread, d_memwrite;
    logic        d_memtoreg, d_regdst, d_regwrite, d_alusrca, d_jal;
    logic [1:0]  d_alusrcb, d_pcsource;
    logic [2:0]  d_aluop;

    // The datapath gates the conditional PC load with zero itself.
    logic unused_zero;
    assign unused_zero = zero;

    // Classify the latched opcode and the R-type ALU funct codes.
    always_comb begin
        op_ok        = 1'b1;
        alu_funct_ok = 1'b1;
        funct_aluop  = ALU_ADD;
        case (opcode)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL: op_ok = 1'b1;
            default:                                           op_ok = 1'b0;
        endcase
        case (funct)
            FN_ADD:  funct_aluop = ALU_ADD;
            FN_SUB:  funct_aluop = ALU_SUB;
            FN_AND:  funct_aluop = ALU_AND;
            FN_OR:   funct_aluop = ALU_OR;
            FN_SLT:  funct_aluop = ALU_SLT;
            default: alu_funct_ok = 1'b0;
        endcase
    end

    // Next-state selection; the first edge after reset parks in FETCH so its outputs go live.
    always_comb begin
        nxt = FETCH;
        if (run_q) begin
            case (state_q)
                FETCH:    nxt = mem_ready ? DECODE : FETCH;
                DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: nxt = MEMADR;
                        OP_R:         nxt = (funct == FN_JR) ? JR : RTYPE_EX;
                        OP_BEQ:       nxt = BRANCH;
                        OP_ADDI:      nxt = ADDI_EX;
                        OP_J:         nxt = JUMP;
                        OP_JAL:       nxt = JAL;
                        default:      nxt = FETCH;
                    endcase
                end
                MEMADR:   nxt = (opcode == OP_SW) ? MEMWR : MEMRD;
                MEMRD:    nxt = mem_ready ? MEMWB : MEMRD;
                MEMWR:    nxt = mem_ready ? FETCH : MEMWR;
                RTYPE_EX: nxt = alu_funct_ok ? RTYPE_WB : FETCH;
                ADDI_EX:  nxt = ADDI_WB;
                default:  nxt = FETCH;
            endcase
        end
    end

    // Moore control values for the state being entered, loaded into the output flops.
    always_comb begin
        d_pcwrite     = 1'b0;
        d_pcwritecond = 1'b0;
        d_iord        = 1'b0;
        d_memread     = 1'b0;
        d_memwrite    = 1'b0;
        d_memtoreg    = 1'b0;
        d_regdst      = 1'b0;
        d_regwrite    = 1'b0;
        d_alusrca     = 1'b0;
        d_jal         = 1'b0;
        d_alusrcb     = 2'b00;
        d_pcsource    = 2'b00;
        d_aluop       = ALU_ADD;
        case (nxt)
            FETCH: begin
                d_memread = 1'b1;
                d_alusrcb = 2'b01;
            end
            DECODE: begin
                d_alusrcb = 2'b11;
            end
            MEMADR: begin
                d_alusrca = 1'b1;
                d_alusrcb = 2'b10;
            end
            MEMRD: begin
                d_iord    = 1'b1;
                d_memread = 1'b1;
            end
            MEMWB: begin
                d_memtoreg = 1'b1;
                d_regwrite = 1'b1;
            end
            MEMWR: begin
                d_iord     = 1'b1;
                d_memwrite = 1'b1;
            end
            RTYPE_EX: begin
                d_alusrca = 1'b1;
                d_aluop   = funct_aluop;
            end
            RTYPE_WB: begin
                d_regdst   = 1'b1;
                d_regwrite = 1'b1;
            end
            BRANCH: begin
                d_alusrca     = 1'b1;
                d_aluop       = ALU_SUB;
                d_pcwritecond = 1'b1;
                d_pcsource    = 2'b01;
            end
            ADDI_EX: begin
                d_alusrca = 1'b1;
                d_alusrcb = 2'b10;
            end
            ADDI_WB: begin
                d_regwrite = 1'b1;
            end
            JUMP: begin
                d_pcwrite  = 1'b1;
                d_pcsource = 2'b10;
            end
            JAL: begin
                d_pcwrite  = 1'b1;
                d_pcsource = 2'b10;
                d_jal      = 1'b1;
                d_regwrite = 1'b1;
            end
            JR: begin
                d_pcwrite  = 1'b1;
                d_pcsource = 2'b11;
            end
            default: begin
                d_pcwrite = 1'b0;
            end
        endcase
    end

    // State register and registered controls; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q         <= 1'b0;
            state_q       <= FETCH;
            pcwrite_q     <= 1'b0;
            pcwritecond_q <= 1'b0;
            iord_q        <= 1'b0;
            memread_q     <= 1'b0;
            memwrite_q    <= 1'b0;
            memtoreg_q    <= 1'b0;
            regdst_q      <= 1'b0;
            regwrite_q    <= 1'b0;
            alusrca_q     <= 1'b0;
            jal_q         <= 1'b0;
            alusrcb_q     <= 2'b00;
            pcsource_q    <= 2'b00;
            aluop_q       <= ALU_ADD;
        end else begin
            run_q         <= 1'b1;
            state_q       <= nxt;
            pcwrite_q     <= d_pcwrite;
            pcwritecond_q <= d_pcwritecond;
            iord_q        <= d_iord;
            memread_q     <= d_memread;
            memwrite_q    <= d_memwrite;
            memtoreg_q    <= d_memtoreg;
            regdst_q      <= d_regdst;
            regwrite_q    <= d_regwrite;
            alusrca_q     <= d_alusrca;
            jal_q         <= d_jal;
            alusrcb_q     <= d_alusrcb;
            pcsource_q    <= d_pcsource;
            aluop_q       <= d_aluop;
        end
    end

    // IR load and PC increment in FETCH wait for the shared memory to deliver.
    assign in_fetch    = run_q && (state_q == FETCH);
    assign IRWrite     = in_fetch & mem_ready;
    assign PCWrite     = run_q ? (pcwrite_q | (in_fetch & mem_ready)) : RESET_PC_WRITE;
    assign PCWriteCond = pcwritecond_q;
    assign IorD        = iord_q;
    assign MemRead     = memread_q;
    assign MemWrite    = memwrite_q;
    assign MemToReg    = memtoreg_q;
    assign RegDst      = regdst_q;
    assign RegWrite    = regwrite_q;
    assign ALUSrcA     = alusrca_q;
    assign Jal         = jal_q;
    assign ALUSrcB     = alusrcb_q;
    assign PCSource    = pcsource_q;
    assign ALUop       = aluop_q;
    assign state       = state_q;

    // Illegal is raised in the cycle the bad opcode or funct is seen, then FETCH follows.
    assign illegal = run_q && (((state_q == DECODE) && !op_ok) ||
                               ((state_q == RTYPE_EX) && !alu_funct_ok));

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_q;
    logic [31:0] instr_q;

    // Free-running cycle count and fetched-instruction count, both wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q <= 32'd0;
            instr_q <= 32'd0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (IRWrite) begin
                instr_q <= instr_q + 32'd1;
            end
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
`else
    assign cycle_cnt = 32'd0;
    assign instr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemToReg, RegDst, RegWrite, ALUSrcA, Jal;
    logic [1:0]  ALUSrcB, PCSource;
    logic [2:0]  ALUop;
    logic        illegal;
    logic [3:0]  state;
    logic [31:0] cycle_cnt, instr_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int ncyc     = 0;
    int ninstr   = 0;

    logic [17:0] ctrl_obs;
    assign ctrl_obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                       MemToReg, RegDst, RegWrite, ALUSrcA, Jal, ALUSrcB, PCSource, ALUop};

    multicycle_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .Jal(Jal), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUop(ALUop),
        .illegal(illegal), .state(state), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit is_valid_op(logic [5:0] op);
        return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
               op == 6'h08 || op == 6'h02 || op == 6'h03;
    endfunction

    function automatic bit is_alu_fn(logic [5:0] fn);
        return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A;
    endfunction

    function automatic logic [2:0] alu_of(logic [5:0] fn);
        if (fn == 6'h22) return 3'b001;
        if (fn == 6'h24) return 3'b010;
        if (fn == 6'h25) return 3'b011;
        if (fn == 6'h2A) return 3'b100;
        return 3'b000;
    endfunction

    // Control vector the datapath should see in a given state.
    function automatic logic [17:0] exp_ctrl(int st, logic [5:0] fn, logic mr);
        logic pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, jl;
        logic [1:0] asb, pcs;
        logic [2:0] op;
        {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, jl} = 11'd0;
        asb = 2'b00; pcs = 2'b00; op = 3'b000;
        case (st)
            0:  begin mrd = 1; asb = 2'b01; pcw = mr; irw = mr; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin iord = 1; mrd = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mwr = 1; end
            6:  begin asa = 1; op = alu_of(fn); end
            7:  begin rdst = 1; rw = 1; end
            8:  begin asa = 1; op = 3'b001; pcc = 1; pcs = 2'b01; end
            9:  begin asa = 1; asb = 2'b10; end
            10: rw = 1;
            11: begin pcw = 1; pcs = 2'b10; end
            12: begin pcw = 1; pcs = 2'b10; jl = 1; rw = 1; end
            13: begin pcw = 1; pcs = 2'b11; end
            default: op = 3'b000;
        endcase
        return {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, jl, asb, pcs, op};
    endfunction

    task automatic check_reset(input string tag);
        n_assert++;
        assert (ctrl_obs === 18'd0) else begin
            n_fail++; $error("FAIL %s ctrl observed=%h expected=%h", tag, ctrl_obs, 18'd0);
        end
        n_assert++;
        assert ({state, illegal} === 5'd0) else begin
            n_fail++; $error("FAIL %s state/illegal observed=%h expected=0", tag, {state, illegal});
        end
        n_assert++;
        assert ({cycle_cnt, instr_cnt} === 64'd0) else begin
            n_fail++; $error("FAIL %s counters observed=%0d/%0d expected=0/0", tag, cycle_cnt, instr_cnt);
        end
    endtask

    task automatic check_cycle(input int st, input logic [5:0] op, input logic [5:0] fn);
        logic [17:0] e;
        logic        e_ill;
        logic [31:0] e_cc, e_ic;
        e     = exp_ctrl(st, fn, mem_ready);
        e_ill = (st == 1 && !is_valid_op(op)) || (st == 6 && !is_alu_fn(fn));
`ifdef MC_PERF_CNT_EN
        e_cc = 32'(ncyc);
        e_ic = 32'(ninstr);
`else
        e_cc = 32'd0;
        e_ic = 32'd0;
`endif
        n_assert++;
        assert (state === 4'(st)) else begin
            n_fail++; $error("FAIL state op=%h fn=%h observed=%0d expected=%0d", op, fn, state, st);
        end
        n_assert++;
        assert (ctrl_obs === e) else begin
            n_fail++; $error("FAIL ctrl st=%0d op=%h fn=%h mr=%b observed=%h expected=%h",
                             st, op, fn, mem_ready, ctrl_obs, e);
        end
        n_assert++;
        assert (illegal === e_ill) else begin
            n_fail++; $error("FAIL illegal st=%0d op=%h fn=%h observed=%b expected=%b",
                             st, op, fn, illegal, e_ill);
        end
        n_assert++;
        assert (cycle_cnt === e_cc && instr_cnt === e_ic) else begin
            n_fail++; $error("FAIL counters observed=%0d/%0d expected=%0d/%0d",
                             cycle_cnt, instr_cnt, e_cc, e_ic);
        end
    endtask

    // mode 0: mem always ready; 1: random ready; 2: two stall cycles in data-memory states;
    // 3: stall forever in data memory and return after five cycles (for reset tests).
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zin,
                             input int mode, input int exp_len);
        int steps[$];
        int idx    = 0;
        int cyc    = 0;
        int stalls = 0;
        int st;
        bit done   = 0;
        if (!is_valid_op(op))                   steps = {0, 1};
        else if (op == 6'h23)                   steps = {0, 1, 2, 3, 4};
        else if (op == 6'h2B)                   steps = {0, 1, 2, 5};
        else if (op == 6'h04)                   steps = {0, 1, 8};
        else if (op == 6'h08)                   steps = {0, 1, 9, 10};
        else if (op == 6'h02)                   steps = {0, 1, 11};
        else if (op == 6'h03)                   steps = {0, 1, 12};
        else if (fn == 6'h08)                   steps = {0, 1, 13};
        else if (is_alu_fn(fn))                 steps = {0, 1, 6, 7};
        else                                    steps = {0, 1, 6};
        while (!done) begin
            @(negedge clk);
            ncyc++;
            if (cyc == 0) begin
                opcode = op;
                funct  = fn;
            end
            st = steps[idx];
            case (mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = 1'($urandom_range(0, 1));
                2:       mem_ready = !((st == 3 || st == 5) && stalls < 2);
                default: mem_ready = !(st == 3 || st == 5);
            endcase
            if (!mem_ready && (st == 3 || st == 5)) stalls++;
            zero = zin;
            #1;
            check_cycle(st, op, fn);
            cyc++;
            if (st == 0 && mem_ready) ninstr++;
            if (!((st == 0 || st == 3 || st == 5) && !mem_ready)) idx++;
            if (idx == steps.size()) done = 1;
            if (mode == 3 && cyc == 5) done = 1;
            if (cyc > 200) begin
                n_assert++;
                n_fail++;
                $error("FAIL timeout op=%h fn=%h cycles=%0d", op, fn, cyc);
                done = 1;
            end
        end
        if (exp_len > 0) begin
            n_assert++;
            assert (cyc == exp_len) else begin
                n_fail++; $error("FAIL latency op=%h fn=%h observed=%0d expected=%0d", op, fn, cyc, exp_len);
            end
        end
    endtask

    initial begin
        logic [5:0] rop, rfn;
        logic [5:0] ops[8];
        logic [5:0] fns[7];
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h03, 6'h3F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08, 6'h3F};

        // Reset held: everything zero regardless of mem_ready.
        mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_reset("reset_hold");
        end
        rst = 1'b1;
        ncyc = 0;
        ninstr = 0;

        // Directed instructions with ready memory, plus fixed stalls.
        run_instr(6'h00, 6'h20, 1'b0, 0, 4);
        run_instr(6'h00, 6'h20, 1'b0, 0, 4);
        run_instr(6'h00, 6'h20, 1'b0, 0, 4);
        run_instr(6'h23, 6'h00, 1'b0, 2, 7);
        run_instr(6'h04, 6'h00, 1'b0, 0, 3);
        run_instr(6'h04, 6'h00, 1'b1, 0, 3);
        run_instr(6'h03, 6'h00, 1'b0, 0, 3);
        run_instr(6'h00, 6'h08, 1'b0, 0, 3);
        run_instr(6'h3F, 6'h00, 1'b0, 0, 2);
        run_instr(6'h00, 6'h3F, 1'b0, 0, 3);
        run_instr(6'h2B, 6'h00, 1'b0, 0, 4);
        run_instr(6'h2B, 6'h00, 1'b0, 2, 6);
        run_instr(6'h08, 6'h00, 1'b0, 0, 4);
        run_instr(6'h02, 6'h00, 1'b0, 0, 3);
        run_instr(6'h23, 6'h00, 1'b0, 0, 5);
        run_instr(6'h00, 6'h22, 1'b0, 0, 4);
        run_instr(6'h00, 6'h24, 1'b0, 0, 4);
        run_instr(6'h00, 6'h25, 1'b0, 0, 4);
        run_instr(6'h00, 6'h2A, 1'b0, 0, 4);

        // Reset asserted while stalled in MEMRD, checked asynchronously and across an edge.
        run_instr(6'h23, 6'h00, 1'b0, 3, -1);
        #2 rst = 1'b0;
        #1 check_reset("reset_async");
        @(negedge clk);
        #1 check_reset("reset_mid");
        rst = 1'b1;
        ncyc = 0;
        ninstr = 0;

        // Randomized instruction stream with random memory readiness.
        for (int i = 0; i < 150; i++) begin
            rop = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) rop = 6'($urandom_range(0, 63));
            rfn = (rop == 6'h00) ? fns[$urandom_range(0, 6)] : 6'($urandom_range(0, 63));
            run_instr(rop, rfn, 1'($urandom_range(0, 1)), 1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
